// File: rtl/ttl_piso_tx.sv
// Framed parallel-in/serial-out transmitter (74165-style, MSB first) with
// start/stop bits, valid/ready load handshake and a clock-inhibit hold input.
module ttl_piso_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [DivW-1:0]  div_q;
  logic [BitW-1:0]  bit_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_shift;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
  logic             div_end;
  logic             accept;

  assign div_end  = (div_q == DivLast);
  assign sr_shift = sr_q << 1;

  // Ready in IDLE, or in the final active STOP cycle so frames can abut.
  assign load_ready = (state_q == StIdle) ||
                      ((state_q == StStop) && div_end && !hold);
  assign accept     = load_valid && load_ready;

  assign sout = sout_q;
  assign busy = busy_q;
  // done_q marks the final STOP position; an inhibited cycle there is not final.
  assign done = done_q && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      state_q <= StStart;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= din;
      sout_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if ((state_q != StIdle) && !hold) begin
      done_q <= 1'b0;
      if (!div_end) begin
        div_q <= div_q + DivW'(1);
        if ((state_q == StStop) && ((div_q + DivW'(1)) == DivLast)) begin
          done_q <= 1'b1;
        end
      end else begin
        div_q <= '0;
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            bit_q   <= '0;
            sout_q  <= sr_q[WIDTH-1];
          end
          StData: begin
            sr_q <= sr_shift;
            if (bit_q == BitLast) begin
              state_q <= StStop;
              sout_q  <= 1'b1;
              done_q  <= (DIV == 1);
            end else begin
              bit_q  <= bit_q + BitW'(1);
              sout_q <= sr_shift[WIDTH-1];
            end
          end
          StStop: begin
            state_q <= StIdle;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
          StIdle: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttl_piso_tx.sv
// Bench for ttl_piso_tx: frame-level reference model plus directed sequences
// on a WIDTH=8/DIV=4 instance and a table-driven WIDTH=4/DIV=1 instance.
module tb_ttl_piso_tx;

  localparam int W0 = 8;
  localparam int D0 = 4;
  localparam int W1 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W0-1:0] din0;
  logic          lv0, hold0;
  logic          ready0, sout0, busy0, done0;
  logic [W1-1:0] din1;
  logic          lv1, hold1;
  logic          ready1, sout1, busy1, done1;

  ttl_piso_tx #(.WIDTH(W0), .DIV(D0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din0), .load_valid(lv0), .load_ready(ready0),
    .hold(hold0), .sout(sout0), .busy(busy0), .done(done0)
  );

  ttl_piso_tx #(.WIDTH(W1), .DIV(D1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .load_valid(lv1), .load_ready(ready1),
    .hold(hold1), .sout(sout1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  typedef struct { bit active; int pos; int word; } model_t;
  typedef struct { logic sout; logic busy; logic done; logic ready; } obs_t;

  model_t m0 = '{0, 0, 0};
  model_t m1 = '{0, 0, 0};
  obs_t   obs0, obs1;

  logic l_sout [0:99];
  logic l_busy [0:99];
  logic l_done [0:99];

  // Frame symbol idx: 0 = start, 1..w = data MSB first, w+1 = stop.
  function automatic bit frame_bit(int word, int w, int idx);
    if (idx == 0) return 1'b0;
    if (idx >= w + 1) return 1'b1;
    return bit'((word >> (w - idx)) & 1);
  endfunction

  function automatic obs_t model_out(model_t m, int w, int d, bit hold);
    obs_t o;
    bit last;
    if (!m.active) begin
      o.sout = 1'b1; o.busy = 1'b0; o.done = 1'b0; o.ready = 1'b1;
    end else begin
      last    = (m.pos == (w + 2) * d - 1);
      o.sout  = frame_bit(m.word, w, m.pos / d);
      o.busy  = 1'b1;
      o.done  = last && !hold;
      o.ready = last && !hold;
    end
    return o;
  endfunction

  function automatic model_t model_next(model_t m, int w, int d, bit r, bit lv, bit hold,
                                        int din);
    model_t n;
    obs_t o;
    n = m;
    o = model_out(m, w, d, hold);
    if (r) begin
      n.active = 1'b0;
    end else if (lv && o.ready) begin
      n.active = 1'b1; n.pos = 0; n.word = din;
    end else if (m.active && !hold) begin
      if (m.pos == (w + 2) * d - 1) n.active = 1'b0;
      else n.pos = m.pos + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compare both instances against the model mid-cycle, then advance one edge.
  task automatic tick();
    obs_t e0, e1;
    @(negedge clk);
    obs0.sout = sout0; obs0.busy = busy0; obs0.done = done0; obs0.ready = ready0;
    obs1.sout = sout1; obs1.busy = busy1; obs1.done = done1; obs1.ready = ready1;
    e0 = model_out(m0, W0, D0, hold0);
    e1 = model_out(m1, W1, D1, hold1);
    if (check_en) begin
      check("m0_sout", obs0.sout, e0.sout);
      check("m0_busy", obs0.busy, e0.busy);
      check("m0_done", obs0.done, e0.done);
      check("m0_ready", obs0.ready, e0.ready);
      check("m1_sout", obs1.sout, e1.sout);
      check("m1_busy", obs1.busy, e1.busy);
      check("m1_done", obs1.done, e1.done);
      check("m1_ready", obs1.ready, e1.ready);
    end
    @(posedge clk);
    m0 = model_next(m0, W0, D0, rst, lv0, hold0, int'(din0));
    m1 = model_next(m1, W1, D1, rst, lv1, hold1, int'(din1));
    #1;
  endtask

  task automatic log_tick(input int i);
    tick();
    l_sout[i] = obs0.sout; l_busy[i] = obs0.busy; l_done[i] = obs0.done;
  endtask

  typedef struct {
    bit lv; logic [W1-1:0] din;
    bit e_sout; bit e_busy; bit e_done; bit e_ready;
  } vec_t;

  vec_t tbl [8];
  bit   a5_bits [10];
  int   cnt, idx;

  initial begin
    a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    tbl[0] = '{1, 4'h9, 1, 0, 0, 1};
    tbl[1] = '{1, 4'h3, 0, 1, 0, 0};
    tbl[2] = '{1, 4'h3, 1, 1, 0, 0};
    tbl[3] = '{1, 4'h3, 0, 1, 0, 0};
    tbl[4] = '{0, 4'h0, 0, 1, 0, 0};
    tbl[5] = '{0, 4'h0, 1, 1, 0, 0};
    tbl[6] = '{0, 4'h0, 1, 1, 1, 1};
    tbl[7] = '{0, 4'h0, 1, 0, 0, 1};

    rst = 1; lv0 = 0; hold0 = 0; din0 = '0; lv1 = 0; hold1 = 0; din1 = '0;
    tick(); tick();
    rst = 0; check_en = 1;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_sout", obs0.sout, 1); check("idle_busy", obs0.busy, 0);
    end
    check("idle_done", obs0.done, 0); check("idle_ready", obs0.ready, 1);

    // Single 0xA5 frame
    din0 = 8'hA5; lv0 = 1; tick(); lv0 = 0; din0 = 8'h5A;
    for (int i = 0; i < 44; i++) log_tick(i);
    for (int k = 0; k < 10; k++) begin
      check("a5_bit_first", l_sout[k*4], a5_bits[k]);
      check("a5_bit_last", l_sout[k*4+3], a5_bits[k]);
    end
    cnt = 0; idx = -1;
    for (int i = 0; i < 44; i++) begin
      if (l_busy[i] === 1'b1) cnt++;
      if (l_done[i] === 1'b1) idx = i;
    end
    check("a5_busy_len", cnt, 40); check("a5_done_cycle", idx, 39);

    // Back-to-back 0xFF then 0x00
    din0 = 8'hFF; lv0 = 1; tick(); din0 = 8'h00;
    for (int i = 0; i < 80; i++) begin
      log_tick(i);
      if (i == 39) lv0 = 0;
    end
    check("b2b_done1", l_done[39], 1); check("b2b_gap_start", l_sout[40], 0);
    cnt = 0;
    for (int i = 0; i < 80; i++) if (l_busy[i] === 1'b1) cnt++;
    check("b2b_busy", cnt, 80);
    cnt = 0;
    for (int i = 44; i < 76; i++) if (l_sout[i] !== 1'b0) cnt++;
    check("b2b_zero_data", cnt, 0);
    check("b2b_stop", l_sout[76], 1); check("b2b_done2", l_done[79], 1);
    tick(); check("b2b_idle", obs0.busy, 0);

    // Hold for 3 cycles inside bit 2
    din0 = 8'hA5; lv0 = 1; tick(); lv0 = 0;
    for (int i = 0; i < 46; i++) begin
      hold0 = (i >= 13 && i <= 15);
      log_tick(i);
    end
    hold0 = 0;
    cnt = 0;
    for (int i = 12; i <= 18; i++) if (l_sout[i] === 1'b1) cnt++;
    check("hold_bit2_len", cnt, 7); check("hold_bit3", l_sout[19], 0);
    cnt = 0; idx = -1;
    for (int i = 0; i < 46; i++) begin
      if (l_busy[i] === 1'b1) cnt++;
      if (l_done[i] === 1'b1) idx = i;
    end
    check("hold_busy_len", cnt, 43); check("hold_done_cycle", idx, 42);

    // Reset mid-frame, then reload right after release
    din0 = 8'hA5; lv0 = 1; tick(); lv0 = 0;
    for (int i = 0; i < 10; i++) log_tick(i);
    rst = 1; log_tick(10); rst = 0;
    din0 = 8'h3C; lv0 = 1; log_tick(11); lv0 = 0;
    check("rst_sout", l_sout[11], 1); check("rst_busy", l_busy[11], 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) if (l_done[i] === 1'b1) cnt++;
    check("rst_no_done", cnt, 0);
    tick(); check("reload_start", obs0.sout, 0); check("reload_busy", obs0.busy, 1);
    for (int i = 0; i < 45; i++) tick();

    // DIV=1 table with ignored loads
    for (int i = 0; i < 8; i++) begin
      lv1 = tbl[i].lv; din1 = tbl[i].din;
      tick();
      check("tbl_sout", obs1.sout, tbl[i].e_sout);
      check("tbl_busy", obs1.busy, tbl[i].e_busy);
      check("tbl_done", obs1.done, tbl[i].e_done);
      check("tbl_ready", obs1.ready, tbl[i].e_ready);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      lv0   = $urandom_range(0, 3) == 0; din0 = W0'($urandom);
      hold0 = $urandom_range(0, 7) == 0;
      lv1   = $urandom_range(0, 1) == 0; din1 = W1'($urandom);
      hold1 = $urandom_range(0, 5) == 0;
      tick();
    end
    rst = 0; lv0 = 0; lv1 = 0; hold0 = 0; hold1 = 0;
    for (int i = 0; i < 60; i++) tick();
    check("end_idle0", obs0.busy, 0); check("end_idle1", obs1.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
